// File: rtl/fir_sample_buffer.sv
// fir_sample_buffer
//   Upstream feeder for the 63-tap FIR stage. Incoming signed samples go into
//   a DEPTH-entry circular history buffer. After every DECIM accepted samples
//   the FIR is started with a one-cycle ready pulse. A frozen offset tells the
//   FIR which entry holds the newest sample. New starts are held off until the
//   FIR reports done, and input that outpaces the filter raises a sticky
//   overrun flag.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   sample_in     incoming signed audio sample (WIDTH bits)
//   valid_in      single-cycle strobe qualifying sample_in (no backpressure)
//   fir_done_in   done pulse from the FIR stage
//   sample_out    history buffer contents, unpacked [DEPTH-1:0]
//   offset_out    index of the newest sample at the last FIR start
//   ready_out     one-cycle pulse that starts the FIR
//   busy_out      high while waiting for the FIR to finish
//   overrun_out   sticky overrun flag, cleared only by reset
//   overrun_count_out  (only with FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN defined)
//                 saturating 8-bit count of overrun events
//
// Build option
//   FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN : adds overrun_count_out.

module fir_sample_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int DECIM = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic signed [WIDTH-1:0]    sample_in,
  input  logic                       valid_in,
  input  logic                       fir_done_in,
  output logic signed [WIDTH-1:0]    sample_out [DEPTH-1:0],
  output logic [$clog2(DEPTH)-1:0]   offset_out,
  output logic                       ready_out,
  output logic                       busy_out,
  output logic                       overrun_out
`ifdef FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN
  ,
  output logic [7:0]                 overrun_count_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [7:0] DECIM_U8 = 8'(DECIM);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [7:0]       dec_cnt;
  logic [7:0]       dec_cnt_inc;
  logic [1:0]       busy_wr_cnt;
  logic             trigger;
  logic             drop;
  logic             hit2;

  always_comb begin
    wr_ptr_nxt  = wr_ptr + 1'b1;
    dec_cnt_inc = dec_cnt + 8'd1;
    trigger     = valid_in && (dec_cnt_inc == DECIM_U8);
    // A trigger arriving while the FIR still runs is dropped, including on
    // the edge where fir_done_in returns.
    drop        = (state == BUSY) && trigger;
    // Second write during a run overwrites the oldest entry the FIR reads.
    hit2        = (state == BUSY) && valid_in && (busy_wr_cnt == 2'd1);
  end

  // History buffer: newest sample always lives at the post-increment pointer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_out <= '{default: '0};
    end else if (valid_in) begin
      sample_out[wr_ptr_nxt] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      dec_cnt     <= '0;
      offset_out  <= '0;
      ready_out   <= 1'b0;
      busy_out    <= 1'b0;
      overrun_out <= 1'b0;
      busy_wr_cnt <= '0;
    end else begin
      ready_out <= 1'b0;

      if (valid_in) begin
        wr_ptr  <= wr_ptr_nxt;
        dec_cnt <= trigger ? '0 : dec_cnt_inc;
      end

      if (drop || hit2) begin
        overrun_out <= 1'b1;
      end

      if (state == IDLE) begin
        // fir_done_in is deliberately ignored here (stray post-reset pulse).
        if (trigger) begin
          state       <= BUSY;
          offset_out  <= wr_ptr_nxt;
          ready_out   <= 1'b1;
          busy_out    <= 1'b1;
          busy_wr_cnt <= '0;
        end
      end else begin
        if (valid_in && (busy_wr_cnt != 2'd2)) begin
          busy_wr_cnt <= busy_wr_cnt + 2'd1;
        end
        if (fir_done_in) begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      end
    end
  end

`ifdef FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN
  logic [1:0] ovr_events;
  logic [8:0] ovr_sum;

  // A dropped trigger and a second busy write can coincide: count both.
  always_comb begin
    ovr_events = {1'b0, drop} + {1'b0, hit2};
    ovr_sum    = {1'b0, overrun_count_out} + {7'd0, ovr_events};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overrun_count_out <= '0;
    end else begin
      overrun_count_out <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_fir_sample_buffer.sv
// Testbench for fir_sample_buffer: two instances (DECIM=1 and DECIM=4) share
// identical stimulus and are compared every cycle against a behavioural model.

module tb_fir_sample_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic signed [15:0]  sample;
  logic                valid;
  logic                done;

  logic signed [15:0]  buf1 [63:0];
  logic signed [15:0]  buf4 [63:0];
  logic [5:0]          off1, off4;
  logic                rdy1, rdy4, busy1, busy4, ovr1, ovr4;
`ifdef FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN
  logic [7:0]          ocnt1, ocnt4;
`endif

  fir_sample_buffer #(.DEPTH(64), .WIDTH(16), .DECIM(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .valid_in(valid),
    .fir_done_in(done), .sample_out(buf1), .offset_out(off1),
    .ready_out(rdy1), .busy_out(busy1), .overrun_out(ovr1)
`ifdef FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN
    , .overrun_count_out(ocnt1)
`endif
  );

  fir_sample_buffer #(.DEPTH(64), .WIDTH(16), .DECIM(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .valid_in(valid),
    .fir_done_in(done), .sample_out(buf4), .offset_out(off4),
    .ready_out(rdy4), .busy_out(busy4), .overrun_out(ovr4)
`ifdef FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN
    , .overrun_count_out(ocnt4)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model, one slot per instance.
  int                 decim [2] = '{1, 4};
  logic signed [15:0] m_mem [2][64];
  int                 m_ptr [2];
  int                 m_off [2];
  int                 m_cnt [2];
  int                 m_bw  [2];
  int                 m_oc  [2];
  bit                 m_rdy [2];
  bit                 m_busy[2];
  bit                 m_ovr [2];

  int seen_rdy [2];
  int q_off1 [$];
  int q_off4 [$];

  task automatic model_edge(input int d, input bit v, input logic signed [15:0] s,
                            input bit dn, input bit r);
    bit trig;
    int ev;
    if (r) begin
      for (int k = 0; k < 64; k++) m_mem[d][k] = '0;
      m_ptr[d] = 0; m_off[d] = 0; m_cnt[d] = 0; m_bw[d] = 0; m_oc[d] = 0;
      m_rdy[d] = 0; m_busy[d] = 0; m_ovr[d] = 0;
    end else begin
      m_rdy[d] = 0;
      trig = 0;
      if (v) begin
        m_ptr[d] = (m_ptr[d] + 1) % 64;
        m_mem[d][m_ptr[d]] = s;
        m_cnt[d]++;
        if (m_cnt[d] == decim[d]) begin
          m_cnt[d] = 0;
          trig = 1;
        end
      end
      if (!m_busy[d]) begin
        if (trig) begin
          m_off[d] = m_ptr[d]; m_rdy[d] = 1; m_busy[d] = 1; m_bw[d] = 0;
        end
      end else begin
        ev = 0;
        if (v && m_bw[d] < 2) begin
          m_bw[d]++;
          if (m_bw[d] == 2) ev++;
        end
        if (trig) ev++;
        if (dn) m_busy[d] = 0;
        if (ev > 0) m_ovr[d] = 1;
        m_oc[d] = (m_oc[d] + ev > 255) ? 255 : m_oc[d] + ev;
      end
    end
  endtask

  task automatic chk_dut(input int d);
    logic signed [15:0] act [63:0];
    logic [5:0] a_off;
    logic a_rdy, a_busy, a_ovr;
    int bad;
    if (d == 0) begin
      act = buf1; a_off = off1; a_rdy = rdy1; a_busy = busy1; a_ovr = ovr1;
    end else begin
      act = buf4; a_off = off4; a_rdy = rdy4; a_busy = busy4; a_ovr = ovr4;
    end
    if (a_rdy === 1'b1) begin
      seen_rdy[d]++;
      if (d == 0) q_off1.push_back(int'(a_off)); else q_off4.push_back(int'(a_off));
    end
    checks++;
    assert (a_rdy === m_rdy[d]) else begin
      errors++; $error("FAIL ready[%0d] got %0b exp %0b", d, a_rdy, m_rdy[d]);
    end
    checks++;
    assert (a_busy === m_busy[d]) else begin
      errors++; $error("FAIL busy[%0d] got %0b exp %0b", d, a_busy, m_busy[d]);
    end
    checks++;
    assert (a_ovr === m_ovr[d]) else begin
      errors++; $error("FAIL overrun[%0d] got %0b exp %0b", d, a_ovr, m_ovr[d]);
    end
    checks++;
    assert (a_off === 6'(m_off[d])) else begin
      errors++; $error("FAIL offset[%0d] got %0d exp %0d", d, a_off, m_off[d]);
    end
    bad = 0;
    for (int k = 63; k >= 0; k--) if (act[k] !== m_mem[d][k]) bad = k;
    checks++;
    assert (act[bad] === m_mem[d][bad]) else begin
      errors++; $error("FAIL buffer[%0d][%0d] got %0d exp %0d", d, bad, act[bad], m_mem[d][bad]);
    end
`ifdef FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN
    checks++;
    assert (((d == 0) ? ocnt1 : ocnt4) === 8'(m_oc[d])) else begin
      errors++; $error("FAIL ocount[%0d] got %0d exp %0d", d, (d == 0) ? ocnt1 : ocnt4, m_oc[d]);
    end
`endif
  endtask

  task automatic step(input bit v, input logic signed [15:0] s, input bit dn, input bit r);
    valid = v; sample = s; done = dn; rst = r;
    @(posedge clk);
    model_edge(0, v, s, dn, r);
    model_edge(1, v, s, dn, r);
    #1;
    chk_dut(0);
    chk_dut(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  task automatic expect_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; done = 1'b0; sample = '0;
    seen_rdy = '{0, 0};

    // Reset state.
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    expect_eq("reset_busy", int'(busy1), 0);
    expect_eq("reset_off", int'(off1), 0);
    expect_eq("reset_buf0", int'(buf1[0]), 0);

    // Stray done in IDLE is ignored.
    step(0, '0, 1, 0);
    expect_eq("idle_done_busy", int'(busy1), 0);
    expect_eq("idle_done_ready", int'(rdy1), 0);

    // Three samples, done 65 cycles after each ready.
    q_off1.delete(); seen_rdy[0] = 0;
    step(1, 16'sd100, 0, 0);   idle(64); step(0, '0, 1, 0);
    step(1, -16'sd200, 0, 0);  idle(64); step(0, '0, 1, 0);
    step(1, 16'sd300, 0, 0);   idle(64); step(0, '0, 1, 0);
    expect_eq("t1_buf1", int'(buf1[1]), 100);
    expect_eq("t1_buf2", int'(buf1[2]), -200);
    expect_eq("t1_buf3", int'(buf1[3]), 300);
    expect_eq("t1_nready", seen_rdy[0], 3);
    expect_eq("t1_noff", q_off1.size(), 3);
    if (q_off1.size() == 3) begin
      expect_eq("t1_off0", q_off1[0], 1);
      expect_eq("t1_off1", q_off1[1], 2);
      expect_eq("t1_off2", q_off1[2], 3);
    end
    expect_eq("t1_ovr", int'(ovr1), 0);

    // 70 samples with wrap, done returned promptly.
    step(0, '0, 0, 1);
    for (int i = 0; i < 70; i++) begin
      step(1, 16'(i), 0, 0);
      step(0, '0, 1, 0);
    end
    expect_eq("t2_buf6", int'(buf1[6]), 69);
    expect_eq("t2_buf0", int'(buf1[0]), 63);
    expect_eq("t2_off", int'(off1), 6);
    expect_eq("t2_ovr", int'(ovr1), 0);

    // DECIM=4: ready only after samples 4, 8, 12.
    step(0, '0, 0, 1);
    q_off4.delete(); seen_rdy[1] = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 16'(i * 7), 0, 0);
      idle(69);
      step(0, '0, 1, 0);
      idle(29);
    end
    expect_eq("t3_nready", seen_rdy[1], 3);
    expect_eq("t3_noff", q_off4.size(), 3);
    if (q_off4.size() == 3) begin
      expect_eq("t3_off0", q_off4[0], 4);
      expect_eq("t3_off1", q_off4[1], 8);
      expect_eq("t3_off2", q_off4[2], 12);
    end

    // Second sample while still busy: dropped trigger, overrun.
    step(0, '0, 0, 1);
    seen_rdy[0] = 0;
    step(1, 16'sd11, 0, 0);
    idle(9);
    step(1, 16'sd22, 0, 0);
    idle(5);
    expect_eq("t4_nready", seen_rdy[0], 1);
    expect_eq("t4_ovr", int'(ovr1), 1);
    expect_eq("t4_off", int'(off1), 1);
    expect_eq("t4_busy", int'(busy1), 1);
    step(0, '0, 1, 0);
    expect_eq("t4_busy_after", int'(busy1), 0);
    expect_eq("t4_ovr_sticky", int'(ovr1), 1);

    // Reset while busy, then stray done, then a fresh start.
    step(0, '0, 0, 1);
    step(1, 16'sd55, 0, 0);
    idle(3);
    step(1, 16'sd66, 0, 1);
    expect_eq("t5_busy", int'(busy1), 0);
    expect_eq("t5_buf1", int'(buf1[1]), 0);
    step(0, '0, 1, 0);
    expect_eq("t5_done_ign", int'(busy1), 0);
    step(1, 16'sd77, 0, 0);
    expect_eq("t5_ready", int'(rdy1), 1);
    expect_eq("t5_off", int'(off1), 1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0), 16'($urandom), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 599) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_buffer.md
Name: fir_sample_buffer

Overview:
- Upstream feeder for the 63-tap FIR stage: captures incoming signed audio samples into a 64-entry circular history buffer.
- Presents the whole buffer, a frozen newest-sample offset and a one-cycle ready pulse to the FIR.
- Runs a decimation counter and holds off new FIR starts until the FIR reports done.
- Flags overruns when the input rate outpaces the filter.

Parameters:
- DEPTH, 64, history length; power of two; offset width = log2(DEPTH) = 6.
- WIDTH, 16, sample width (signed).
- DECIM, 1, accepted samples per FIR start; legal range 1..255.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- sample_in  input  WIDTH signed  incoming audio sample.
- valid_in  input  1  sample_in is valid this cycle; single-cycle strobe; no backpressure.
- fir_done_in  input  1  done pulse from the FIR stage.
- sample_out  output  WIDTH signed x DEPTH (unpacked [DEPTH-1:0])  history buffer contents.
- offset_out  output  6  index of the newest sample at the last FIR start.
- ready_out  output  1  one-cycle pulse that starts the FIR.
- busy_out  output  1  high while waiting for the FIR to finish.
- overrun_out  output  1  sticky overrun flag.

Behaviour:
- Reset, synchronous:
  - All sample_out entries = 0; internal write pointer wr_ptr = 0; offset_out = 0.
  - ready_out = 0, busy_out = 0, overrun_out = 0; decimation count = 0; state = IDLE.
  - Reset mid-operation abandons the current FIR run; any later fir_done_in is ignored while in IDLE.
- Write path (any state), on a clock edge with valid_in = 1:
  - wr_ptr <= wr_ptr + 1, wrapping 63 -> 0.
  - sample_out[wr_ptr + 1] <= sample_in. The entry at the pointer after the increment always holds the newest sample.
- Decimation:
  - Count increments on each accepted sample.
  - When an accepted sample makes the count reach DECIM, the count returns to 0 and a trigger is raised on that same edge.
  - With DECIM = 1, every sample triggers.
- State machine: IDLE, BUSY.
  - IDLE + trigger on edge T: offset_out <= new wr_ptr; ready_out <= 1 for exactly the cycle after T; busy_out <= 1; state <= BUSY; in-busy write count <= 0.
  - BUSY: offset_out is frozen. Each accepted sample increments the in-busy write count, saturating at 2.
  - BUSY + fir_done_in = 1: state <= IDLE; busy_out <= 0 on the next edge.
  - IDLE + fir_done_in: ignored. This covers the FIR's post-reset stray done pulse.
- Overrun conditions (each sets overrun_out; cleared only by reset):
  - A trigger occurs while in BUSY. That trigger is dropped and no ready pulse is issued.
  - The in-busy write count reaches 2. The second write overwrites entry offset_out-62, which the FIR still reads.
- Simultaneous events:
  - fir_done_in and a trigger on the same edge while BUSY: the trigger is treated as occurring in BUSY. It is dropped, overrun_out is set, and state -> IDLE.
  - valid_in and reset on the same edge: reset wins; the sample is discarded.
- Latency: sample accepted on edge T is visible on sample_out after T. ready_out is high in cycle T+1 with offset_out already pointing at that sample.
- Arithmetic: the pointer is 6-bit modulo-64. The decimation counter is 8-bit and compared against DECIM.

Optional Feature:
- Macro: FIR_SAMPLE_BUFFER_OVERRUN_CNT_EN.
- Defined: adds output port overrun_count_out (8 bits).
  - Increments by 1 on every overrun event, i.e. each dropped trigger and each transition of the in-busy write count to 2.
  - Saturates at 255; reset value 0.
- Undefined: the port is absent. overrun_out behaviour is identical in both builds.

Test Plan:
- Reset then 3 samples 100, -200, 300 with DECIM=1 and fir_done_in pulsed 65 cycles after each ready -> sample_out[1..3] = 100, -200, 300; three ready pulses with offset_out = 1, 2, 3; overrun_out = 0.
- 70 consecutive samples, value = sample index, DECIM=1, done returned promptly -> wrap occurs; sample_out[6] = 69; final offset_out = 6; sample_out[0] = 63.
- DECIM=4, 12 samples spaced 100 cycles apart -> ready pulses only after samples 4, 8, 12; offset_out = 4, 8, 12.
- DECIM=1, second sample 10 cycles after the first ready with no done yet -> no second ready pulse; overrun_out = 1; offset_out stays 1; busy_out stays 1 until done.
- fir_done_in pulsed in IDLE after reset -> no state change; busy_out = 0; ready_out = 0.
- Reset asserted while BUSY -> busy_out = 0 and buffer entries zero on the next cycle. A following done pulse is ignored. The next sample produces ready with offset_out = 1.
